// File: rtl/codeword_pkg.sv
// Shared types and widths for the codeword detection datapath (LFSR + 1011111 detector + session control).
package codeword_pkg;

  localparam int unsigned LFSR_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned HIT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    REPORT
  } state_e;

  typedef logic [1:0] status_t;

  localparam status_t ST_TARGET  = 2'b00;
  localparam status_t ST_TIMEOUT = 2'b01;
  localparam status_t ST_ABORT   = 2'b10;
  localparam status_t ST_BADCFG  = 2'b11;

endpackage

// File: rtl/codeword_scan_ctrl_if.sv
// Session-control bundle: config/start, LFSR/detector control, and the result valid/ready channel.
interface codeword_scan_ctrl_if;
  import codeword_pkg::*;

  logic              start;
  logic [LFSR_W-1:0] seed;
  logic [CNT_W-1:0]  max_cycles;
  logic [HIT_W-1:0]  target_hits;
  logic              abort;
  logic              busy;
  logic              lfsr_load;
  logic [LFSR_W-1:0] lfsr_seed;
  logic              lfsr_en;
  logic              det_rst_n;
  logic              det_hit;
  logic              res_valid;
  logic              res_ready;
  logic [HIT_W-1:0]  res_hits;
  logic [CNT_W-1:0]  res_first;
  logic [CNT_W-1:0]  res_cycles;
  status_t           res_status;

  // Controller side
  modport master (
    input  start, seed, max_cycles, target_hits, abort, det_hit, res_ready,
    output busy, lfsr_load, lfsr_seed, lfsr_en, det_rst_n,
           res_valid, res_hits, res_first, res_cycles, res_status
  );

  // Environment side (datapath + result consumer)
  modport slave (
    output start, seed, max_cycles, target_hits, abort, det_hit, res_ready,
    input  busy, lfsr_load, lfsr_seed, lfsr_en, det_rst_n,
           res_valid, res_hits, res_first, res_cycles, res_status
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; exposes its next value for same-cycle compares.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt_c
);

  always_comb begin
    count_nxt_c = count;
    if (clr) begin
      count_nxt_c = '0;
    end else if (inc && (count != '1)) begin
      count_nxt_c = count + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/codeword_scan_ctrl.sv
// Session controller: seeds the LFSR, runs it for a bounded window, counts detector hits
// and reports the outcome over a valid/ready result channel.
module codeword_scan_ctrl
  import codeword_pkg::*;
#(
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  codeword_scan_ctrl_if.master bus
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e            state_q, state_d;
  status_t           status_q, status_d;
  logic [LFSR_W-1:0] seed_q;
  logic [CNT_W-1:0]  max_q, cnt_q, first_q, cur_cyc_c;
  logic [HIT_W-1:0]  target_q, hits_q, hits_nxt_c;
  logic [DRAIN_W-1:0] drain_q;
  logic              cnt_clr_c, hit_inc_c, first_set_c, target_met_c;
  logic              busy_q, lfsr_load_q, lfsr_en_q, det_rst_n_q, res_valid_q;

  sat_counter #(.W(HIT_W)) u_hits (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr_c),
    .inc        (hit_inc_c),
    .count      (hits_q),
    .count_nxt_c(hits_nxt_c)
  );

  // Next-state and status; abort is evaluated last so it overrides target and timeout.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    cnt_clr_c    = 1'b0;
    hit_inc_c    = 1'b0;
    cur_cyc_c    = cnt_q;
    target_met_c = (target_q != '0) && (hits_nxt_c == target_q);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_clr_c = 1'b1;
          if ((bus.max_cycles == '0) || (bus.seed == '0)) begin
            state_d  = REPORT;
            status_d = ST_BADCFG;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_clr_c = 1'b1;
        state_d   = RUN;
        if (bus.abort) begin
          state_d  = REPORT;
          status_d = ST_ABORT;
        end
      end
      RUN: begin
        hit_inc_c = bus.det_hit;
        cur_cyc_c = cnt_q + CNT_W'(1);
        if (cur_cyc_c == max_q) begin
          state_d = DRAIN;
        end
        if (target_met_c) begin
          state_d  = REPORT;
          status_d = ST_TARGET;
        end
        if (bus.abort) begin
          state_d  = REPORT;
          status_d = ST_ABORT;
        end
      end
      DRAIN: begin
        hit_inc_c = bus.det_hit;
        if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
          state_d  = REPORT;
          status_d = ST_TIMEOUT;
        end
        if (target_met_c) begin
          state_d  = REPORT;
          status_d = ST_TARGET;
        end
        if (bus.abort) begin
          state_d  = REPORT;
          status_d = ST_ABORT;
        end
      end
      REPORT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign first_set_c = hit_inc_c && (hits_q == '0);

  // State, counters, captured config; control outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      status_q    <= ST_TARGET;
      seed_q      <= '0;
      max_q       <= '0;
      target_q    <= '0;
      cnt_q       <= '0;
      first_q     <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      lfsr_load_q <= 1'b0;
      lfsr_en_q   <= 1'b0;
      det_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if ((state_q == IDLE) && bus.start) begin
        seed_q   <= bus.seed;
        max_q    <= bus.max_cycles;
        target_q <= bus.target_hits;
      end
      if (cnt_clr_c) begin
        cnt_q   <= '0;
        first_q <= '0;
      end else begin
        if (state_q == RUN) begin
          cnt_q <= cur_cyc_c;
        end
        if (first_set_c) begin
          first_q <= cur_cyc_c;
        end
      end
      drain_q     <= (state_q == DRAIN) ? drain_q + DRAIN_W'(1) : '0;
      busy_q      <= (state_d != IDLE);
      lfsr_load_q <= (state_d == LOAD);
      lfsr_en_q   <= (state_d == RUN);
      det_rst_n_q <= (state_d == RUN) || (state_d == DRAIN);
      res_valid_q <= (state_d == REPORT);
    end
  end

  assign bus.busy       = busy_q;
  assign bus.lfsr_load  = lfsr_load_q;
  assign bus.lfsr_seed  = seed_q;
  assign bus.lfsr_en    = lfsr_en_q;
  assign bus.det_rst_n  = det_rst_n_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_hits   = hits_q;
  assign bus.res_first  = first_q;
  assign bus.res_cycles = cnt_q;
  assign bus.res_status = status_q;

endmodule

// File: tb/tb_codeword_scan_ctrl.sv
// Randomized self-checking bench for codeword_scan_ctrl against a session-level reference model.
module tb_codeword_scan_ctrl;
  import codeword_pkg::*;

  localparam int unsigned DRAIN_CYC = 2;
  localparam int          PLAN_N    = 512;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   hit_plan [0:PLAN_N-1];

  codeword_scan_ctrl_if bus ();

  codeword_scan_ctrl #(.DRAIN_CYC(DRAIN_CYC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Session outcome from the timeline: t=0 is the load cycle, t=1..max are enable cycles,
  // then DRAIN_CYC drain cycles. Returns the terminating timeline index in end_t.
  function automatic void model(input int s, input int mc, input int tg, input int abort_t,
                                output int st, output int hits, output int first,
                                output int cycles, output int end_t);
    hits = 0; first = 0; cycles = 0;
    if (mc == 0 || s == 0) begin
      st = 3; end_t = -1; return;
    end
    if (abort_t == 0) begin
      st = 2; end_t = 0; return;
    end
    for (int t = 1; t <= mc + int'(DRAIN_CYC); t++) begin
      if (t <= mc) cycles = t;
      if (hit_plan[t]) begin
        if (hits < 255) hits++;
        if (first == 0) first = cycles;
      end
      if (abort_t == t) begin
        st = 2; end_t = t; return;
      end
      if (tg != 0 && hits == tg) begin
        st = 0; end_t = t; return;
      end
    end
    st = 1;
    end_t = mc + int'(DRAIN_CYC);
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < PLAN_N; i++) hit_plan[i] = 1'b0;
  endtask

  task automatic run_session(input string name, input int s, input int mc, input int tg,
                             input int abort_t, input int rdy_dly, input bit busy_start);
    int e_st, e_hits, e_first, e_cyc, e_end, t, bound, bad_t;
    bit pat_bad, seed_bad, stable_bad, exp_load, exp_en, exp_dr;
    model(s, mc, tg, abort_t, e_st, e_hits, e_first, e_cyc, e_end);
    bound    = mc + int'(DRAIN_CYC) + 8;
    pat_bad  = 1'b0;
    seed_bad = 1'b0;
    bad_t    = -1;

    @(negedge clk);
    bus.seed        = LFSR_W'(s);
    bus.max_cycles  = CNT_W'(mc);
    bus.target_hits = HIT_W'(tg);
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    t = 0;
    while (t < bound) begin
      if (bus.res_valid === 1'b1) break;
      exp_load = (t == 0);
      exp_en   = (t >= 1) && (t <= e_cyc);
      exp_dr   = (t >= 1) && (t <= e_end);
      if (!pat_bad && ((bus.lfsr_load !== exp_load) || (bus.lfsr_en !== exp_en) ||
                       (bus.det_rst_n !== exp_dr) || (bus.busy !== 1'b1))) begin
        pat_bad = 1'b1;
        bad_t   = t;
      end
      if (t == 0 && bus.lfsr_seed !== LFSR_W'(s)) seed_bad = 1'b1;
      bus.det_hit = (t < PLAN_N) ? hit_plan[t] : 1'b0;
      bus.abort   = (t == abort_t);
      bus.start   = busy_start && (t == 1);
      @(negedge clk);
      t++;
    end
    bus.det_hit = 1'b0;
    bus.abort   = 1'b0;
    bus.start   = 1'b0;

    n_cmp++;
    if (t != e_end + 1 || bus.res_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s latency: res_valid at t=%0d (valid=%b), expected t=%0d", name, t, bus.res_valid, e_end + 1);
    end
    n_cmp++;
    if (pat_bad) begin
      n_err++;
      $display("FAIL %s ctrl_pattern: first wrong load/en/det_rst_n/busy at t=%0d, expected en 1..%0d det_rst_n 1..%0d", name, bad_t, e_cyc, e_end);
    end
    if (e_end >= 0) begin
      n_cmp++;
      if (seed_bad) begin
        n_err++;
        $display("FAIL %s lfsr_seed: wrong seed during load, expected %0h", name, s);
      end
    end
    n_cmp++;
    if (bus.res_status !== 2'(e_st)) begin
      n_err++;
      $display("FAIL %s status: got %0d expected %0d", name, bus.res_status, e_st);
    end
    n_cmp++;
    if (bus.res_hits !== HIT_W'(e_hits)) begin
      n_err++;
      $display("FAIL %s hits: got %0d expected %0d", name, bus.res_hits, e_hits);
    end
    n_cmp++;
    if (bus.res_first !== CNT_W'(e_first)) begin
      n_err++;
      $display("FAIL %s first: got %0d expected %0d", name, bus.res_first, e_first);
    end
    n_cmp++;
    if (bus.res_cycles !== CNT_W'(e_cyc)) begin
      n_err++;
      $display("FAIL %s cycles: got %0d expected %0d", name, bus.res_cycles, e_cyc);
    end

    stable_bad = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      bus.start = busy_start && (i == 0);
      bus.seed  = LFSR_W'($urandom_range(1, 255));
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.res_valid !== 1'b1 || bus.res_status !== 2'(e_st) || bus.res_hits !== HIT_W'(e_hits) ||
          bus.res_first !== CNT_W'(e_first) || bus.res_cycles !== CNT_W'(e_cyc) ||
          bus.lfsr_en !== 1'b0 || bus.lfsr_load !== 1'b0 || bus.det_rst_n !== 1'b0)
        stable_bad = 1'b1;
    end
    if (rdy_dly > 0) begin
      n_cmp++;
      if (stable_bad) begin
        n_err++;
        $display("FAIL %s report_hold: result or control changed while res_ready low (st=%0d hits=%0d)", name, bus.res_status, bus.res_hits);
      end
    end

    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.det_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL %s handshake: valid=%b busy=%b det_rst_n=%b, expected 0 0 0", name, bus.res_valid, bus.busy, bus.det_rst_n);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.lfsr_load !== 1'b0 || bus.lfsr_en !== 1'b0 || bus.det_rst_n !== 1'b0 ||
        bus.res_valid !== 1'b0 || bus.lfsr_seed !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b load=%b en=%b det_rst_n=%b valid=%b seed=%0h, expected all 0",
               bus.busy, bus.lfsr_load, bus.lfsr_en, bus.det_rst_n, bus.res_valid, bus.lfsr_seed);
    end
    n_cmp++;
    if (bus.res_hits !== '0 || bus.res_first !== '0 || bus.res_cycles !== '0 || bus.res_status !== 2'b00) begin
      n_err++;
      $display("FAIL reset_result: hits=%0d first=%0d cycles=%0d status=%0d, expected 0", bus.res_hits, bus.res_first, bus.res_cycles, bus.res_status);
    end
  endtask

  task automatic test_timeout();
    clear_plan(); hit_plan[3] = 1'b1; hit_plan[7] = 1'b1;
    run_session("timeout", 8'h5A, 10, 0, -1, 2, 1'b0);
  endtask

  task automatic test_target();
    clear_plan(); hit_plan[5] = 1'b1; hit_plan[9] = 1'b1;
    run_session("target", 8'h01, 100, 2, -1, 0, 1'b0);
  endtask

  task automatic test_drain_hit();
    clear_plan(); hit_plan[5] = 1'b1;
    run_session("drain_hit", 8'h33, 4, 0, -1, 1, 1'b0);
  endtask

  task automatic test_abort();
    clear_plan(); hit_plan[6] = 1'b1;
    run_session("abort_vs_target", 8'hC3, 20, 1, 6, 0, 1'b0);
    clear_plan(); hit_plan[0] = 1'b1;
    run_session("abort_in_load", 8'h11, 20, 1, 0, 0, 1'b0);
  endtask

  task automatic test_bad_config();
    clear_plan();
    run_session("badcfg_seed0", 8'h00, 5, 0, -1, 5, 1'b1);
    run_session("badcfg_max0", 8'h42, 0, 3, -1, 5, 1'b1);
  endtask

  task automatic test_saturation();
    clear_plan();
    for (int i = 0; i < PLAN_N; i++) hit_plan[i] = 1'b1;
    run_session("saturate", 8'h77, 300, 0, -1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.seed = 8'h3C; bus.max_cycles = 16'd50; bus.target_hits = 8'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.det_hit = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.det_hit = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.det_rst_n !== 1'b0 || bus.res_valid !== 1'b0 || bus.lfsr_en !== 1'b0 ||
        bus.res_hits !== '0 || bus.res_cycles !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run: busy=%b det_rst_n=%b valid=%b en=%b hits=%0d cycles=%0d, expected all 0",
               bus.busy, bus.det_rst_n, bus.res_valid, bus.lfsr_en, bus.res_hits, bus.res_cycles);
    end
    rst_n = 1'b1;
    clear_plan(); hit_plan[2] = 1'b1;
    run_session("after_reset", 8'h3C, 6, 0, -1, 0, 1'b0);
  endtask

  // Back-to-back randomized sessions; each start lands the cycle after the prior handshake.
  task automatic test_back_to_back();
    int s, mc, tg, ab, dens;
    for (int n = 0; n < 40; n++) begin
      s    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      mc   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      tg   = int'($urandom_range(0, 4));
      dens = int'($urandom_range(0, 50));
      ab   = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, mc + DRAIN_CYC)) : -1;
      clear_plan();
      for (int i = 0; i <= mc + int'(DRAIN_CYC) + 2; i++)
        hit_plan[i] = (int'($urandom_range(0, 99)) < dens);
      run_session($sformatf("rand%0d", n), s, mc, tg, ab, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.seed        = '0;
    bus.max_cycles  = '0;
    bus.target_hits = '0;
    bus.abort       = 1'b0;
    bus.det_hit     = 1'b0;
    bus.res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_timeout();
    test_target();
    test_drain_hit();
    test_abort();
    test_bad_config();
    test_saturation();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
